// File: rtl/tc_pl_cap_gain_dac_wr.sv
// Serial writer for the dual-channel capture-gain DAC: shifts frame A then frame B over SPI,
// strobes LDAC so both channels update together, then reports complete to the gain controller.
`timescale 1ns/1ps
module tc_pl_cap_gain_dac_wr #(
    parameter int DATA_W   = 32,
    parameter int SCLK_DIV = 4,
    parameter int CS_GAP   = 8,
    parameter int LDAC_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gset_en,
    input  logic [DATA_W-1:0] gset_dacA,
    input  logic [DATA_W-1:0] gset_dacB,
    output logic              gset_adc_cmpt,
    output logic              dac_busy,
    output logic              dac_csn,
    output logic              dac_sclk,
    output logic              dac_sdi,
    output logic              dac_ldacn,
    output logic [2:0]        dbg_state
);

    // Handshake: gset_en is a level request held until gset_adc_cmpt is seen; cmpt stays high
    // until gset_en falls, and gset_en falling before cmpt aborts the request with no cmpt.

    localparam int CNT_MAX = (SCLK_DIV > CS_GAP) ? ((SCLK_DIV > LDAC_W) ? SCLK_DIV : LDAC_W)
                                                 : ((CS_GAP > LDAC_W) ? CS_GAP : LDAC_W);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
    localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_W - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT_A = 3'd1,
        S_GAP_A   = 3'd2,
        S_SHIFT_B = 3'd3,
        S_GAP_B   = 3'd4,
        S_LDAC    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              half_q, half_d;
    logic              abort_q, abort_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              csn_q, csn_d;
    logic              sclk_q, sclk_d;
    logic              sdi_q, sdi_d;
    logic              ldacn_q, ldacn_d;
    logic              cmpt_q, cmpt_d;
    logic              busy_q, busy_d;

    logic div_end, bit_last, gap_end, ldac_end, gap_go;

    assign div_end  = (cnt_q == DIV_LAST);
    assign bit_last = (bit_q == BIT_LAST) && half_q;
    assign gap_end  = (cnt_q == GAP_LAST);
    assign ldac_end = (cnt_q == LDAC_LAST);
    assign gap_go   = gap_end && !abort_q && gset_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            half_q  <= 1'b0;
            abort_q <= 1'b0;
            sh_q    <= '0;
            b_q     <= '0;
            csn_q   <= 1'b1;
            sclk_q  <= 1'b0;
            sdi_q   <= 1'b0;
            ldacn_q <= 1'b1;
            cmpt_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            abort_q <= abort_d;
            sh_q    <= sh_d;
            b_q     <= b_d;
            csn_q   <= csn_d;
            sclk_q  <= sclk_d;
            sdi_q   <= sdi_d;
            ldacn_q <= ldacn_d;
            cmpt_q  <= cmpt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        half_d  = half_q;
        abort_d = abort_q;
        sh_d    = sh_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE: begin
                if (gset_en) begin
                    state_d = S_SHIFT_A;
                    sh_d    = gset_dacA;
                    b_d     = gset_dacB;
                    cnt_d   = '0;
                    bit_d   = '0;
                    half_d  = 1'b0;
                    abort_d = 1'b0;
                end
            end
            S_SHIFT_A, S_SHIFT_B: begin
                // A dropped request is remembered so the frame still runs to its end.
                if (!gset_en) abort_d = 1'b1;
                if (div_end) begin
                    cnt_d  = '0;
                    half_d = ~half_q;
                    if (half_q) begin
                        sh_d  = sh_q << 1;
                        bit_d = bit_q + 1'b1;
                        if (bit_last) begin
                            bit_d   = '0;
                            state_d = (state_q == S_SHIFT_A) ? S_GAP_A : S_GAP_B;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP_A, S_GAP_B: begin
                cnt_d = gap_end ? '0 : cnt_q + 1'b1;
                if (!abort_q && !gset_en) begin
                    state_d = S_IDLE;
                end else if (gap_end) begin
                    if (abort_q)                state_d = S_IDLE;
                    else if (state_q == S_GAP_A) begin
                        state_d = S_SHIFT_B;
                        sh_d    = b_q;
                    end else                    state_d = S_LDAC;
                end
            end
            S_LDAC: begin
                cnt_d = ldac_end ? '0 : cnt_q + 1'b1;
                if (!gset_en)      state_d = S_IDLE;
                else if (ldac_end) state_d = S_DONE;
            end
            S_DONE: begin
                if (!gset_en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        csn_d   = csn_q;
        sclk_d  = sclk_q;
        sdi_d   = sdi_q;
        ldacn_d = ldacn_q;
        cmpt_d  = cmpt_q;
        case (state_q)
            S_IDLE: begin
                if (gset_en) begin
                    csn_d  = 1'b0;
                    sclk_d = 1'b0;
                    sdi_d  = gset_dacA[DATA_W-1];
                end
            end
            S_SHIFT_A, S_SHIFT_B: begin
                // sdi moves only on the falling SCLK edge, giving SCLK_DIV cycles of setup and hold.
                if (div_end) begin
                    sclk_d = ~half_q;
                    if (half_q) begin
                        if (bit_last) csn_d = 1'b1;
                        else          sdi_d = sh_q[DATA_W-2];
                    end
                end
            end
            S_GAP_A: begin
                if (gap_go) begin
                    csn_d = 1'b0;
                    sdi_d = b_q[DATA_W-1];
                end
            end
            S_GAP_B: begin
                if (gap_go) ldacn_d = 1'b0;
            end
            S_LDAC: begin
                if (!gset_en) begin
                    ldacn_d = 1'b1;
                end else if (ldac_end) begin
                    ldacn_d = 1'b1;
                    cmpt_d  = 1'b1;
                end
            end
            S_DONE: begin
                if (!gset_en) cmpt_d = 1'b0;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    assign gset_adc_cmpt = cmpt_q;
    assign dac_busy      = busy_q;
    assign dac_csn       = csn_q;
    assign dac_sclk      = sclk_q;
    assign dac_sdi       = sdi_q;
    assign dac_ldacn     = ldacn_q;
    assign dbg_state     = state_q;

endmodule

// File: doc/tc_pl_cap_gain_dac_wr.md
# tc_pl_cap_gain_dac_wr

Serial writer for the dual-channel capture-gain DAC, downstream of the capture gain controller. On a `gset_en` request it latches the selected DAC A and B codes and shifts each out as a separate SPI frame. It then pulses LDAC so both channels update together, and returns `gset_adc_cmpt` to the gain controller. The gain controller's set phase advances only when this block reports complete.

## Interface
- `DATA_W`, default 32: bits per DAC frame, sent MSB first; legal range 8..32.
- `SCLK_DIV`, default 4: clk cycles per SCLK half-period; legal ≥1.
- `CS_GAP`, default 8: minimum clk cycles `dac_csn` stays high after each frame; legal ≥1.
- `LDAC_W`, default 4: clk cycles `dac_ldacn` is held low; legal ≥1.

- `clk`, input, 1: single clock domain.
- `rst`, input, 1: reset, asynchronous, active-high.
- `gset_en`, input, 1: level request from the gain controller; held high until complete is seen.
- `gset_dacA`, input, DATA_W: channel A frame, sampled at request start.
- `gset_dacB`, input, DATA_W: channel B frame, sampled at request start.
- `gset_adc_cmpt`, output, 1: level complete; high from end of LDAC until `gset_en` falls.
- `dac_busy`, output, 1: high in every state except IDLE and DONE.
- `dac_csn`, output, 1: SPI chip select, active low.
- `dac_sclk`, output, 1: SPI clock; idles low.
- `dac_sdi`, output, 1: SPI data; DAC samples it on rising SCLK.
- `dac_ldacn`, output, 1: DAC load strobe, active low.

## Operation
- All outputs are registered. Reset values: `gset_adc_cmpt`=0, `dac_busy`=0, `dac_csn`=1, `dac_sclk`=0, `dac_sdi`=0, `dac_ldacn`=1. The state returns to IDLE immediately on reset, including mid-frame.
- **IDLE**
  - Exits when `gset_en`=1 is sampled.
  - On that edge: latch A and B into shadow registers, drive `dac_csn`=0 and `dac_sdi`=A[DATA_W-1], go to SHIFT_A.
  - Input changes after the latch are ignored until the next request.
- **SHIFT_A / SHIFT_B**
  - Each bit period is 2*SCLK_DIV cycles: SCLK low for the first half, high for the second.
  - `dac_sdi` changes only when SCLK falls, and at frame start.
  - A bit counter counts 0..DATA_W-1. After the last period ends, SCLK=0 and csn=1.
  - Next state: SHIFT_A goes to GAP_A; SHIFT_B goes to GAP_B.
- **GAP_A**: csn high for CS_GAP cycles, then drive csn=0 and `dac_sdi`=B[MSB], go to SHIFT_B.
- **GAP_B**: CS_GAP cycles, then drive `dac_ldacn`=0, go to LDAC.
- **LDAC**: after LDAC_W cycles, drive `dac_ldacn`=1 and `gset_adc_cmpt`=1, go to DONE.
- **DONE**: hold cmpt=1 while `gset_en`=1. When `gset_en`=0, clear cmpt on the next edge and go to IDLE. A new request therefore needs `gset_en` low for at least 1 cycle.
- **Abort when `gset_en` falls:**
  - In SHIFT_x: complete the current frame (never truncate a frame), then respect CS_GAP, then go to IDLE. Skip the remaining frame and LDAC.
  - In GAP_x: go to IDLE on the next edge.
  - In LDAC: `dac_ldacn`=1 and IDLE on the next edge.
  - cmpt is never asserted for an aborted request.
- A new `gset_en` seen in the same cycle as an abort's return to IDLE is not accepted. It is evaluated in IDLE from the next cycle.

## Timing
- Frame length F = 2*SCLK_DIV*DATA_W cycles of csn low; F = 256 with defaults.
- Edge numbering is relative to E0, the edge that samples the request in IDLE.
  - E0: csn falls.
  - E(F): csn rises.
  - E(F+CS_GAP): csn falls for frame B.
  - E(2F+CS_GAP): csn rises.
  - E(2F+2*CS_GAP): ldacn falls.
  - E(2F+2*CS_GAP+LDAC_W): ldacn rises and cmpt rises.
- Defaults: cmpt at E532.
- SCLK edges within a frame, for bit k (0 = MSB):
  - rises at E(2k*SCLK_DIV + SCLK_DIV);
  - falls at E(2(k+1)*SCLK_DIV).
- Setup and hold of sdi to rising SCLK are each SCLK_DIV cycles.
- cmpt falls 1 cycle after `gset_en` is sampled low.
- `dac_busy` rises at E0 and falls on the edge cmpt rises, or on return to IDLE after an abort.

## Test plan
- Defaults, A=0xA5A5_0F0F, B=0x1234_5678, hold `gset_en` → capture 32 SCLK rising-edge samples per frame and check they equal A then B. Check csn low 256 cycles, gap 8, ldacn low 4 cycles, cmpt at E532. Drop `gset_en` → cmpt=0 one cycle later.
- Change `gset_dacA` to 0xFFFF_FFFF at E10 → frame A still shifts 0xA5A5_0F0F.
- Drop `gset_en` at E100, mid frame A → frame A completes at E256, no frame B, ldacn stays 1, cmpt stays 0, IDLE by E264.
- Drop `gset_en` during LDAC → ldacn=1 on next edge, cmpt never rises.
- Assert `rst` at E300 → all outputs at reset values immediately. After release, a fresh request reproduces the full scenario-1 timing.
- SCLK_DIV=1, DATA_W=8, CS_GAP=1, LDAC_W=1 → F=16, cmpt at E35. Hold `gset_en` high continuously → exactly one transaction.
